// File: rtl/mod_mul_rt.sv
// mod_mul_rt: runtime-modulus interleaved modular multiplier, z = x*y mod m.
// Scans y MSB first, one bit per clock, reducing with two conditional subtractions.
module mod_mul_rt #(
  parameter int K    = 192,
  parameter int LOGK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [K-1:0] x_i,
  input  logic [K-1:0] y_i,
  input  logic [K-1:0] m_i,
  output logic [K-1:0] z_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q;
  logic            start_q;
  logic [LOGK-1:0] cnt_q;
  logic [K+1:0]    acc_q;
  logic [K-1:0]    x_q;
  logic [K-1:0]    y_q;
  logic [K-1:0]    m_q;
  logic [K-1:0]    z_q;
  logic            done_q;
  logic            busy_q;
  logic            err_q;

  logic [K+1:0]    m_ext;
  logic [K+1:0]    sum_d;
  logic [K+1:0]    red1_d;
  logic [K+1:0]    acc_d;
  logic            launch_d;
  logic            range_err_d;

  // One interleaved step: t = 2*acc + y_bit*x, then reduce twice (t < 3m).
  // acc is kept at K+2 bits so the shift never loses the carry into the sum.
  always_comb begin
    m_ext       = {2'b00, m_q};
    sum_d       = (acc_q << 1) + (y_q[K-1] ? {2'b00, x_q} : {(K+2){1'b0}});
    red1_d      = (sum_d >= m_ext) ? (sum_d - m_ext) : sum_d;
    acc_d       = (red1_d >= m_ext) ? (red1_d - m_ext) : red1_d;
    launch_d    = start_i & ~start_q & (state_q == IDLE);
    range_err_d = (x_i >= m_i) | (y_i >= m_i) | (m_i < K'(2));
  end

  // Control FSM and datapath registers; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= {LOGK{1'b0}};
      acc_q   <= {(K+2){1'b0}};
      x_q     <= {K{1'b0}};
      y_q     <= {K{1'b0}};
      m_q     <= {K{1'b0}};
      z_q     <= {K{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_i;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch_d) begin
            x_q <= x_i;
            y_q <= y_i;
            m_q <= m_i;
            if (range_err_d) begin
              z_q    <= {K{1'b0}};
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              acc_q   <= {(K+2){1'b0}};
              cnt_q   <= LOGK'(K - 1);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          // y is shifted so its MSB is always the bit for the current step.
          y_q   <= {y_q[K-2:0], 1'b0};
          if (cnt_q == {LOGK{1'b0}}) begin
            z_q     <= acc_d[K-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - LOGK'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign z_o    = z_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_mod_mul_rt.sv
// Scoreboard bench for mod_mul_rt: a K=8 instance and a K=192 instance,
// directed vectors with hand-computed results, checked by done-driven monitors.
module tb_mod_mul_rt;

  localparam int KS = 8;
  localparam int KB = 192;
  localparam logic [191:0] P    = 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF;
  localparam logic [191:0] PM1  = 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFE;
  localparam logic [191:0] PM2  = 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFD;
  localparam logic [191:0] X64  = 192'h000000000000000000000000000000010000000000000001;
  localparam logic [191:0] PROD = 192'h000000000000000100000000000000020000000000000001;

  typedef struct packed {
    logic [191:0] z;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_start;
  logic [7:0]  s_x, s_y, s_m, s_z;
  logic        s_done, s_busy, s_err;
  logic        b_start;
  logic [191:0] b_x, b_y, b_m, b_z;
  logic        b_done, b_busy, b_err;

  exp_t q_s[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_err = 0;

  mod_mul_rt #(.K(KS), .LOGK(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start_i(s_start),
    .x_i(s_x), .y_i(s_y), .m_i(s_m),
    .z_o(s_z), .done_o(s_done), .busy_o(s_busy), .err_o(s_err)
  );

  mod_mul_rt #(.K(KB), .LOGK(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(b_start),
    .x_i(b_x), .y_i(b_y), .m_i(b_m),
    .z_o(b_z), .done_o(b_done), .busy_o(b_busy), .err_o(b_err)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor for the small instance: every done must match a pending operation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_done) begin
      if (q_s.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL s_unexpected_done: done=1 with no pending operation");
      end else begin
        e = q_s.pop_front();
        chk("s_z", 192'(s_z), e.z);
        chk("s_err", 192'(s_err), 192'(e.err));
      end
    end
  end

  // Monitor for the 192-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_done) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_done: done=1 with no pending operation");
      end else begin
        e = q_b.pop_front();
        chk("b_z", b_z, e.z);
        chk("b_err", 192'(b_err), 192'(e.err));
      end
    end
  end

  function automatic logic cur_done(input bit big);
    return big ? b_done : s_done;
  endfunction

  function automatic logic cur_busy(input bit big);
    return big ? b_busy : s_busy;
  endfunction

  task automatic set_start(input bit big, input logic v);
    if (big) b_start = v;
    else     s_start = v;
  endtask

  // mode 0: plain op, 1: hold start across done, 2: disturb inputs and start mid-run
  task automatic run(input bit big, input logic [191:0] x, input logic [191:0] y,
                     input logic [191:0] m, input logic [191:0] ez, input bit eerr,
                     input int mode);
    exp_t e;
    int   n, nbusy, k;
    k     = big ? KB : KS;
    e.z   = ez;
    e.err = eerr;
    @(negedge clk);
    if (big) begin
      b_x = x; b_y = y; b_m = m;
      q_b.push_back(e);
    end else begin
      s_x = x[7:0]; s_y = y[7:0]; s_m = m[7:0];
      q_s.push_back(e);
    end
    set_start(big, 1'b1);
    @(posedge clk); #1;
    n     = 0;
    nbusy = 0;
    while (!cur_done(big) && n < k + 10) begin
      if (cur_busy(big)) nbusy++;
      if (mode != 1 && n == 1) set_start(big, 1'b0);
      if (mode == 2 && n == 40) begin
        b_x = 192'd3; b_y = 192'd3; b_m = 192'd5;
      end
      if (mode == 2 && n == 42) b_start = 1'b1;
      if (mode == 2 && n == 44) b_start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk(big ? "b_latency" : "s_latency", 192'(n), 192'(eerr ? 0 : k));
    chk(big ? "b_busy_cycles" : "s_busy_cycles", 192'(nbusy), 192'(eerr ? 0 : k));
    if (mode != 1) set_start(big, 1'b0);
    @(posedge clk); #1;
    chk(big ? "b_done_cleared" : "s_done_cleared", 192'(cur_done(big)), 192'd0);
    chk(big ? "b_busy_after" : "s_busy_after", 192'(cur_busy(big)), 192'd0);
    if (mode == 1) begin
      repeat (10) @(posedge clk);
      #1;
      chk("b_no_relaunch_busy", 192'(cur_busy(big)), 192'd0);
    end
    set_start(big, 1'b0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    s_start = 1'b0; s_x = 8'd0; s_y = 8'd0; s_m = 8'd0;
    b_start = 1'b0; b_x = 192'd0; b_y = 192'd0; b_m = 192'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_z", 192'(s_z), 192'd0);
    chk("rst_s_flags", 192'({s_done, s_busy, s_err}), 192'd0);
    chk("rst_b_z", b_z, 192'd0);
    chk("rst_b_flags", 192'({b_done, b_busy, b_err}), 192'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    run(1'b0, 192'd0,    192'd0,    192'd1,   192'd0,    1'b1, 0); // m=1
    run(1'b0, 192'hF7,   192'h0A,   192'd251, 192'hD3,   1'b0, 0); // 2470 mod 251
    run(1'b0, 192'd12,   192'd11,   192'd13,  192'd2,    1'b0, 0); // 132 mod 13
    run(1'b1, P,         192'd1,    P,        192'd0,    1'b1, 0); // x=m
    run(1'b1, X64,       X64,       P,        PROD,      1'b0, 0);
    run(1'b1, PM1,       PM1,       P,        192'd1,    1'b0, 0);
    run(1'b1, 192'h123456789ABCDEF0, 192'd0, P, 192'd0,  1'b0, 0);
    run(1'b1, 192'd5,    192'd7,    P,        192'd35,   1'b0, 1); // hold start
    run(1'b1, X64,       X64,       P,        PROD,      1'b0, 2); // disturb mid-run

    // Abort a 192-bit operation after 100 iterations.
    @(negedge clk);
    b_x = PM1; b_y = PM1; b_m = P; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_z", b_z, 192'd0);
    chk("abort_done", 192'(b_done), 192'd0);
    chk("abort_busy", 192'(b_busy), 192'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    run(1'b1, PM1, 192'd2, P, PM2, 1'b0, 0); // 2(m-1) mod m

    repeat (5) @(posedge clk);
    #1;
    chk("s_queue_empty", 192'(q_s.size()), 192'd0);
    chk("b_queue_empty", 192'(q_b.size()), 192'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
